// File: rtl/gray_pkg.sv
// Shared definitions for the grayscale conversion controller.
//   - default channel/accumulator widths and luma weights
//   - FSM state encoding
//   - step counter width for the default pixel width
package gray_pkg;

  localparam int PIX_W_DEF  = 8;
  localparam int ACC_W_DEF  = 16;

  localparam int COEF_R_DEF = 77;
  localparam int COEF_G_DEF = 150;
  localparam int COEF_B_DEF = 29;

  // One step per coefficient bit per channel.
  localparam int STEP_W_DEF = $clog2(3 * PIX_W_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/adder.sv
// Plain unsigned WIDTH-bit adder; the carry out is dropped (modulo 2**WIDTH).
// Ports:
//   a, b : operands
//   s    : a + b truncated to WIDTH bits
module adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s
);

  assign s = a + b;

endmodule

// File: rtl/gray_sum_ctrl.sv
// Grayscale pixel controller: Y = (R*COEF_R + G*COEF_G + B*COEF_B) >> PIX_W,
// computed bit-serially through a single shared adder (one coefficient bit
// per cycle, 3*PIX_W cycles per pixel, fixed latency).
// Ports:
//   aclk, aresetn        : clock, asynchronous active-low reset
//   in_valid/in_ready    : RGB input handshake; in_rgb = {R, G, B}
//   out_valid/out_ready  : gray output handshake; out_gray held while stalled
//   busy                 : high while a pixel is being accumulated or waiting
//
// state | meaning
// IDLE  | waiting for a pixel, in_ready high
// ACCUM | one shift-and-add step per cycle over R, G, B coefficient bits
// DONE  | result valid, waiting for out_ready
module gray_sum_ctrl
  import gray_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int COEF_R = COEF_R_DEF,
  parameter int COEF_G = COEF_G_DEF,
  parameter int COEF_B = COEF_B_DEF
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3*PIX_W-1:0] in_rgb,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   out_gray,
  output logic               busy
);

  localparam int STEP_W = $clog2(3 * PIX_W);
  localparam int IDX_W  = (PIX_W > 1) ? $clog2(PIX_W) : 1;

  localparam logic [PIX_W-1:0]  COEF_R_V  = COEF_R[PIX_W-1:0];
  localparam logic [PIX_W-1:0]  COEF_G_V  = COEF_G[PIX_W-1:0];
  localparam logic [PIX_W-1:0]  COEF_B_V  = COEF_B[PIX_W-1:0];
  localparam logic [STEP_W-1:0] G_BASE    = STEP_W'(PIX_W);
  localparam logic [STEP_W-1:0] B_BASE    = STEP_W'(2 * PIX_W);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(3 * PIX_W - 1);

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   r_q, g_q, b_q;
  logic [ACC_W-1:0]   acc_q;
  logic [STEP_W-1:0]  step_q;
  logic [PIX_W-1:0]   gray_q;

  logic [PIX_W-1:0]   chan;
  logic [PIX_W-1:0]   coef;
  logic [IDX_W-1:0]   bit_idx;
  logic [ACC_W-1:0]   term;
  logic [ACC_W-1:0]   sum;
  logic               accept;
  logic               last_step;

  adder #(.WIDTH(ACC_W)) u_adder (
    .a (acc_q),
    .b (term),
    .s (sum)
  );

  // Select channel and coefficient bit for the current step, then form the
  // partial product chan << i (or zero when that coefficient bit is clear).
  always_comb begin
    chan    = '0;
    coef    = '0;
    bit_idx = '0;
    if (step_q < G_BASE) begin
      chan    = r_q;
      coef    = COEF_R_V;
      bit_idx = IDX_W'(step_q);
    end else if (step_q < B_BASE) begin
      chan    = g_q;
      coef    = COEF_G_V;
      bit_idx = IDX_W'(step_q - G_BASE);
    end else begin
      chan    = b_q;
      coef    = COEF_B_V;
      bit_idx = IDX_W'(step_q - B_BASE);
    end
    term = coef[bit_idx] ? (ACC_W'(chan) << bit_idx) : '0;
  end

  // Gated by aresetn so the source sees in_ready low for the whole reset.
  assign in_ready  = (state_q == IDLE) && aresetn;
  assign accept    = in_valid && (state_q == IDLE);
  assign last_step = (step_q == LAST_STEP);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ACCUM) || (state_q == DONE);
  assign out_gray  = gray_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ACCUM;
      ACCUM:   if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      step_q <= '0;
      gray_q <= '0;
    end else if (accept) begin
      r_q    <= in_rgb[3*PIX_W-1:2*PIX_W];
      g_q    <= in_rgb[2*PIX_W-1:PIX_W];
      b_q    <= in_rgb[PIX_W-1:0];
      acc_q  <= '0;
      step_q <= '0;
    end else if (state_q == ACCUM) begin
      acc_q  <= sum;
      step_q <= step_q + 1'b1;
      // Capture the final sum directly so out_gray is stable from DONE entry.
      if (last_step) gray_q <= sum[2*PIX_W-1:PIX_W];
    end
  end

endmodule

// File: tb/tb_gray_sum_ctrl.sv
// Directed and randomized checks for gray_sum_ctrl (default parameters).
module tb_gray_sum_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_rgb = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_gray;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 aclk = ~aclk;

  gray_sum_ctrl dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rgb    (in_rgb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] exp_gray;
  } vec_t;

  vec_t vecs [8];

  function automatic int ref_gray(input logic [23:0] rgb);
    int r, g, b;
    r = int'(rgb[23:16]);
    g = int'(rgb[15:8]);
    b = int'(rgb[7:0]);
    return (r * 77 + g * 150 + b * 29) / 256;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Presents a pixel, waits (bounded) for in_ready, returns just after the accept edge.
  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int n;
    n = 0;
    in_rgb   = {r, g, b};
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'd1, 32'd0);
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until out_valid rises (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!out_valid) chk("out_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int lat;
    int exp_q[$];
    int acc_cyc[$];
    int n_acc, n_out;

    vecs[0] = '{r: 8'd255, g: 8'd0,   b: 8'd0,   exp_gray: 8'd76};
    vecs[1] = '{r: 8'd0,   g: 8'd255, b: 8'd0,   exp_gray: 8'd149};
    vecs[2] = '{r: 8'd0,   g: 8'd0,   b: 8'd255, exp_gray: 8'd28};
    vecs[3] = '{r: 8'd255, g: 8'd255, b: 8'd255, exp_gray: 8'd255};
    vecs[4] = '{r: 8'd0,   g: 8'd0,   b: 8'd0,   exp_gray: 8'd0};
    vecs[5] = '{r: 8'd100, g: 8'd150, b: 8'd200, exp_gray: 8'd140};
    vecs[6] = '{r: 8'd1,   g: 8'd1,   b: 8'd1,   exp_gray: 8'd1};
    vecs[7] = '{r: 8'd10,  g: 8'd20,  b: 8'd30,  exp_gray: 8'd18};

    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_gray", out_gray, 0);
    aresetn = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Table-driven single pixels, out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].r, vecs[i].g, vecs[i].b);
      chk("accum_busy", busy, 1);
      chk("accum_in_ready", in_ready, 0);
      wait_out(lat);
      chk("latency", lat, 24);
      chk("vec_gray", out_gray, vecs[i].exp_gray);
      tick();
      chk("vec_valid_drop", out_valid, 0);
      chk("vec_idle_ready", in_ready, 1);
    end

    // Backpressure: result held stable for 10 stalled cycles
    out_ready = 1'b0;
    send(8'd100, 8'd150, 8'd200);
    wait_out(lat);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_gray", out_gray, 140);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_busy", busy, 1);
    end
    out_ready = 1'b1;
    tick();
    chk("stall_release_valid", out_valid, 0);
    chk("stall_release_ready", in_ready, 1);

    // Back-to-back with in_valid held; in_rgb changed mid-ACCUM
    in_rgb   = {8'd100, 8'd150, 8'd200};
    in_valid = 1'b1;
    n_out    = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (acc_cyc.size() == 2 && cyc > acc_cyc[1]) in_valid = 1'b0;
      if (acc_cyc.size() == 1 && cyc == acc_cyc[0] + 5) in_rgb = '0;
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        exp_q.push_back(ref_gray(in_rgb));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("b2b_spurious", 1, 0);
        else chk("b2b_gray", out_gray, exp_q.pop_front());
        n_out++;
      end
      tick();
    end
    chk("b2b_accepts", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) chk("b2b_period", acc_cyc[1] - acc_cyc[0], 26);
    chk("b2b_outputs", n_out, 2);
    exp_q.delete();

    // Reset in the middle of accumulation
    send(8'd255, 8'd255, 8'd255);
    repeat (10) tick();
    aresetn = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    tick();
    aresetn = 1'b1;
    #1;
    chk("midrst_release_ready", in_ready, 1);
    send(8'd128, 8'd128, 8'd128);
    wait_out(lat);
    chk("midrst_latency", lat, 24);
    chk("midrst_gray", out_gray, 128);
    tick();

    // Random stream with random backpressure against the reference model
    n_acc    = 0;
    n_out    = 0;
    in_rgb   = 24'($urandom);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 80000 && n_out < 1000; cyc++) begin
      logic took;
      took      = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_gray(in_rgb));
        n_acc++;
        took = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("rand_spurious", 1, 0);
        else chk("rand_gray", out_gray, exp_q.pop_front());
        n_out++;
      end
      tick();
      if (took) begin
        in_rgb = 24'($urandom);
        if (n_acc == 1000) in_valid = 1'b0;
      end
    end
    chk("rand_accepted", n_acc, 1000);
    chk("rand_outputs", n_out, 1000);
    chk("rand_leftover", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
